// File: rtl/scirc658_seq.sv
// ---------------------------------------------------------------------------
// scirc658_seq
//
// Control sequencer for a W-bit loadable binary counter. It drives the
// counter's load, count-enable and parallel-data inputs so that the counter
// times a programmable period of N clock cycles. The counter's all-ones carry
// marks the end of each period.
//
// The counter is preset to P = 2^W - N and counts up to all-ones, so it visits
// exactly N values per period. In repeat mode the carry cycle reloads P
// directly, which keeps back-to-back periods seamless.
//
// State table:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start; counter untouched
//   LOAD    | one cycle: counter loads the preset P
//   RUN     | counting; carry ends (one-shot) or reloads (repeat) the period
//
// Ports:
//   clk_i      in   clock, rising edge
//   rst_i      in   asynchronous, active-high reset
//   start_i    in   begin a period (sampled only in IDLE)
//   stop_i     in   abort (sampled in LOAD and RUN, wins over start_i)
//   mode_i     in   0 = one-shot, 1 = repeat (latched with start)
//   period_i   in   period length N, 1..2^W-1 (latched with start)
//   A_i4       in   counter current value (feedback for consistency check)
//   C_i        in   counter all-ones carry (feedback)
//   ld_o       out  counter load
//   cnt_o      out  counter count-enable
//   I_o4       out  counter parallel data (the registered preset P)
//   busy_o     out  high whenever not IDLE
//   done_o     out  one-cycle pulse per completed period
//   err_o      out  sticky error flag (zero period start or bad feedback)
// ---------------------------------------------------------------------------
module scirc658_seq #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic         mode_i,
    input  logic [W-1:0] period_i,
    input  logic [W-1:0] A_i4,
    input  logic         C_i,
    output logic         ld_o,
    output logic         cnt_o,
    output logic [W-1:0] I_o4,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_d;

    logic [W-1:0] preset_q;
    logic         mode_q;
    logic         done_q;
    logic         err_q;

    logic         period_zero;
    logic         start_ok;
    logic         start_bad;
    logic         in_idle;
    logic         in_run;
    logic         fb_err;
    logic         done_d;
    logic [W-1:0] preset_d;

    // ------------------------------------------------------------------
    // Start qualification (only meaningful while IDLE)
    // ------------------------------------------------------------------
    assign in_idle     = (state_q == ST_IDLE);
    assign in_run      = (state_q == ST_RUN);
    assign period_zero = (period_i == '0);

    // stop_i suppresses the start entirely: no latch and no error.
    assign start_ok  = in_idle && start_i && !stop_i && !period_zero;
    assign start_bad = in_idle && start_i && !stop_i &&  period_zero;

    // Two's complement of the requested period: counting up from here
    // reaches all-ones after exactly N visited values.
    assign preset_d = '0 - period_i;

    // Carry and counter value must agree while counting; a mismatch means
    // the counter or its wiring is faulty. Operation is not disturbed.
    assign fb_err = in_run && (C_i != (&A_i4));

    // A completed period is a RUN cycle with carry that was not aborted.
    assign done_d = in_run && C_i && !stop_i;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // The load still happens on this edge even when aborted.
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (C_i && !mode_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (counter controls are combinational on state/feedback)
    // ------------------------------------------------------------------
    always_comb begin
        ld_o  = 1'b0;
        cnt_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ld_o  = 1'b0;
                cnt_o = 1'b0;
            end
            ST_LOAD: begin
                ld_o  = 1'b1;
                cnt_o = 1'b0;
            end
            ST_RUN: begin
                if (stop_i) begin
                    // Abort: counter simply holds its value.
                    ld_o  = 1'b0;
                    cnt_o = 1'b0;
                end else if (!C_i) begin
                    cnt_o = 1'b1;
                end else if (mode_q) begin
                    // Reload in the carry cycle so the next period starts
                    // without a gap.
                    ld_o = 1'b1;
                end else begin
                    // One-shot end: counter holds all-ones.
                    ld_o  = 1'b0;
                    cnt_o = 1'b0;
                end
            end
            default: begin
                ld_o  = 1'b0;
                cnt_o = 1'b0;
            end
        endcase
    end

    assign busy_o = !in_idle;
    assign I_o4   = preset_q;
    assign done_o = done_q;
    assign err_o  = err_q;

    // ------------------------------------------------------------------
    // Configuration latched on an accepted start
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            preset_q <= '0;
            mode_q   <= 1'b0;
        end else if (start_ok) begin
            preset_q <= preset_d;
            mode_q   <= mode_i;
        end
    end

    // ------------------------------------------------------------------
    // Done pulse and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end else if (start_bad || fb_err) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_scirc658_seq.sv
// ---------------------------------------------------------------------------
// tb_scirc658_seq
//
// Directed bench for scirc658_seq. A small behavioural 4-bit loadable counter
// closes the feedback loop; its outputs can be overridden to inject a
// carry/value mismatch. Cycle numbering in comments: cycle 0 is the cycle in
// which start_i is presented. Inputs change 1 time unit after the rising
// edge, outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_scirc658_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] period = '0;
    logic [W-1:0] a_dut;
    logic         c_dut;
    logic         ld;
    logic         cnt;
    logic [W-1:0] i_par;
    logic         busy;
    logic         done;
    logic         err;

    // Counter model and fault injection
    logic [W-1:0] a_cnt = '0;
    logic         frc_en = 1'b0;
    logic [W-1:0] frc_a = '0;
    logic         frc_c = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld) begin
            a_cnt <= i_par;
        end else if (cnt) begin
            a_cnt <= a_cnt + 4'd1;
        end
    end

    assign a_dut = frc_en ? frc_a : a_cnt;
    assign c_dut = frc_en ? frc_c : (&a_cnt);

    scirc658_seq #(.W(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .stop_i   (stop),
        .mode_i   (mode),
        .period_i (period),
        .A_i4     (a_dut),
        .C_i      (c_dut),
        .ld_o     (ld),
        .cnt_o    (cnt),
        .I_o4     (i_par),
        .busy_o   (busy),
        .done_o   (done),
        .err_o    (err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    initial begin
        // ---------------- reset ----------------
        cyc; cyc;
        mid;
        chk("rst_ld",   {7'd0, ld},   8'h0);
        chk("rst_cnt",  {7'd0, cnt},  8'h0);
        chk("rst_i",    {4'd0, i_par}, 8'h0);
        chk("rst_busy", {7'd0, busy}, 8'h0);
        chk("rst_done", {7'd0, done}, 8'h0);
        chk("rst_err",  {7'd0, err},  8'h0);
        cyc; rst = 1'b0;
        cyc;

        // ---------------- one-shot, N=5 ----------------
        cyc; start = 1'b1; period = 4'd5; mode = 1'b0;        // cycle 0
        mid; chk("os_c0_busy", {7'd0, busy}, 8'h0);
        cyc; start = 1'b0;                                      // cycle 1
        mid; chk("os_c1_ld",  {7'd0, ld},  8'h1);
             chk("os_c1_cnt", {7'd0, cnt}, 8'h0);
             chk("os_c1_i",   {4'd0, i_par}, 8'h0b);
             chk("os_c1_busy",{7'd0, busy}, 8'h1);
        cyc;                                                    // cycle 2
        mid; chk("os_c2_cnt", {7'd0, cnt}, 8'h1);
             chk("os_c2_a",   {4'd0, a_cnt}, 8'h0b);
        cyc; cyc; cyc;                                          // cycle 5
        mid; chk("os_c5_cnt", {7'd0, cnt}, 8'h1);
             chk("os_c5_a",   {4'd0, a_cnt}, 8'h0e);
             chk("os_c5_done",{7'd0, done}, 8'h0);
        cyc;                                                    // cycle 6
        mid; chk("os_c6_a",   {4'd0, a_cnt}, 8'h0f);
             chk("os_c6_cnt", {7'd0, cnt}, 8'h0);
             chk("os_c6_ld",  {7'd0, ld},  8'h0);
             chk("os_c6_done",{7'd0, done}, 8'h0);
        cyc;                                                    // cycle 7
        mid; chk("os_c7_done",{7'd0, done}, 8'h1);
             chk("os_c7_busy",{7'd0, busy}, 8'h0);
        cyc;                                                    // cycle 8
        mid; chk("os_c8_done",{7'd0, done}, 8'h0);
             chk("os_c8_a",   {4'd0, a_cnt}, 8'h0f);
             chk("os_c8_err", {7'd0, err}, 8'h0);

        // ---------------- repeat, N=3 ----------------
        cyc; start = 1'b1; period = 4'd3; mode = 1'b1;        // cycle 0
        cyc; start = 1'b0; mode = 1'b0;                         // cycle 1
        mid; chk("rp_c1_i",   {4'd0, i_par}, 8'h0d);
             chk("rp_c1_ld",  {7'd0, ld},  8'h1);
        cyc;                                                    // cycle 2
        mid; chk("rp_c2_a",   {4'd0, a_cnt}, 8'h0d);
        cyc;                                                    // cycle 3
        mid; chk("rp_c3_a",   {4'd0, a_cnt}, 8'h0e);
        cyc;                                                    // cycle 4
        mid; chk("rp_c4_a",   {4'd0, a_cnt}, 8'h0f);
             chk("rp_c4_ld",  {7'd0, ld},  8'h1);
             chk("rp_c4_cnt", {7'd0, cnt}, 8'h0);
             chk("rp_c4_done",{7'd0, done}, 8'h0);
        cyc;                                                    // cycle 5
        mid; chk("rp_c5_done",{7'd0, done}, 8'h1);
             chk("rp_c5_a",   {4'd0, a_cnt}, 8'h0d);
        cyc; start = 1'b1; period = 4'd7;                       // cycle 6: ignored start
        mid; chk("rp_c6_done",{7'd0, done}, 8'h0);
             chk("rp_c6_a",   {4'd0, a_cnt}, 8'h0e);
        cyc; start = 1'b0;                                      // cycle 7
        mid; chk("rp_c7_i",   {4'd0, i_par}, 8'h0d);
             chk("rp_c7_ld",  {7'd0, ld},  8'h1);
        cyc;                                                    // cycle 8
        mid; chk("rp_c8_done",{7'd0, done}, 8'h1);
             chk("rp_c8_a",   {4'd0, a_cnt}, 8'h0d);
        cyc; stop = 1'b1;                                       // cycle 9, A=E
        mid; chk("rp_c9_ld",  {7'd0, ld},  8'h0);
             chk("rp_c9_cnt", {7'd0, cnt}, 8'h0);
        cyc; stop = 1'b0;                                       // cycle 10
        mid; chk("rp_c10_busy",{7'd0, busy}, 8'h0);
        for (int k = 0; k < 3; k++) begin
            mid; chk("rp_hold_done", {7'd0, done}, 8'h0);
                 chk("rp_hold_a",    {4'd0, a_cnt}, 8'h0e);
            cyc;
        end

        // ---------------- repeat, N=1 ----------------
        start = 1'b1; period = 4'd1; mode = 1'b1;              // cycle 0
        cyc; start = 1'b0;                                      // cycle 1
        mid; chk("n1_c1_i",   {4'd0, i_par}, 8'h0f);
        cyc;                                                    // cycle 2
        mid; chk("n1_c2_ld",  {7'd0, ld},  8'h1);
             chk("n1_c2_done",{7'd0, done}, 8'h0);
        cyc;                                                    // cycle 3
        mid; chk("n1_c3_ld",  {7'd0, ld},  8'h1);
             chk("n1_c3_done",{7'd0, done}, 8'h1);
             chk("n1_c3_a",   {4'd0, a_cnt}, 8'h0f);
        cyc;                                                    // cycle 4
        mid; chk("n1_c4_done",{7'd0, done}, 8'h1);
             chk("n1_c4_cnt", {7'd0, cnt}, 8'h0);
        cyc; stop = 1'b1;                                       // cycle 5
        mid; chk("n1_c5_ld",  {7'd0, ld},  8'h0);
             chk("n1_c5_done",{7'd0, done}, 8'h1);
        cyc; stop = 1'b0;                                       // cycle 6
        mid; chk("n1_c6_done",{7'd0, done}, 8'h0);
             chk("n1_c6_busy",{7'd0, busy}, 8'h0);

        // ---------------- zero period, then N=2 ----------------
        cyc; start = 1'b1; period = 4'd0; mode = 1'b0;        // cycle 0
        cyc; start = 1'b0;                                      // cycle 1
        mid; chk("z_busy",    {7'd0, busy}, 8'h0);
             chk("z_err",     {7'd0, err},  8'h1);
        cyc; start = 1'b1; period = 4'd2;                       // cycle 0
        cyc; start = 1'b0;                                      // cycle 1
        mid; chk("n2_c1_err", {7'd0, err},  8'h0);
             chk("n2_c1_i",   {4'd0, i_par}, 8'h0e);
        cyc;                                                    // cycle 2
        mid; chk("n2_c2_cnt", {7'd0, cnt}, 8'h1);
        cyc;                                                    // cycle 3
        mid; chk("n2_c3_done",{7'd0, done}, 8'h0);
        cyc;                                                    // cycle 4
        mid; chk("n2_c4_done",{7'd0, done}, 8'h1);
             chk("n2_c4_busy",{7'd0, busy}, 8'h0);

        // ---------------- start with stop in IDLE ----------------
        cyc; start = 1'b1; stop = 1'b1; period = 4'd9;
        cyc; start = 1'b0; stop = 1'b0;
        mid; chk("ss_busy",   {7'd0, busy}, 8'h0);
             chk("ss_i",      {4'd0, i_par}, 8'h0e);
             chk("ss_err",    {7'd0, err},  8'h0);

        // ---------------- feedback error, then async reset ----------------
        cyc; start = 1'b1; period = 4'd5; mode = 1'b1;        // cycle 0
        cyc; start = 1'b0;                                      // cycle 1
        cyc;                                                    // cycle 2, A=B
        mid; chk("fb_c2_err", {7'd0, err}, 8'h0);
        cyc; frc_en = 1'b1; frc_a = 4'h7; frc_c = 1'b1;        // cycle 3
        mid; chk("fb_c3_ld",  {7'd0, ld},  8'h1);
        cyc; frc_en = 1'b0;                                     // cycle 4
        mid; chk("fb_c4_err", {7'd0, err}, 8'h1);
             chk("fb_c4_done",{7'd0, done}, 8'h1);
             chk("fb_c4_cnt", {7'd0, cnt}, 8'h1);
        #1 rst = 1'b1;
        #1;
        chk("ar_ld",   {7'd0, ld},   8'h0);
        chk("ar_cnt",  {7'd0, cnt},  8'h0);
        chk("ar_busy", {7'd0, busy}, 8'h0);
        chk("ar_done", {7'd0, done}, 8'h0);
        chk("ar_err",  {7'd0, err},  8'h0);
        chk("ar_i",    {4'd0, i_par}, 8'h0);
        cyc; rst = 1'b0;
        cyc;
        mid; chk("post_busy", {7'd0, busy}, 8'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
